// File: rtl/jpeg_byte_packer.sv
// JPEG byte packer: packs encoder bytes into 32-bit words,
// buffers them in a FWFT FIFO and reports per-frame byte length.
module jpeg_byte_packer #(
    parameter int DEPTH_LOG2 = 6,
    parameter int W_LEN      = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_valid_i,
    input  logic [7:0]            data_i,
    input  logic                  pic_ready_i,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [31:0]           m_data,
    output logic [3:0]            m_keep,
    output logic                  m_last,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic [W_LEN-1:0]      frame_len,
    output logic                  frame_len_valid,
    output logic                  overflow,
    output logic                  err_protocol
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        ACC     = 2'd0,
        FLUSH_H = 2'd1,
        FLUSH_P = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [31:0]           part_q, part_d;
    logic [31:0]           hold_q, hold_d;
    logic                  hold_v_q, hold_v_d;
    logic [W_LEN-1:0]      len_q, len_d;
    logic [W_LEN-1:0]      frame_len_q, frame_len_d;
    logic                  flv_q, flv_d;
    logic                  ovf_q, ovf_d;
    logic                  perr_q, perr_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [36:0]           shown_q, shown_d;
    logic [36:0]           mem_q [DEPTH];

    logic [31:0]           new_word;
    logic                  push;
    logic [31:0]           push_word;
    logic [3:0]            push_keep;
    logic                  push_last;
    logic                  push_ok;
    logic                  pop;
    logic                  full;
    logic [36:0]           head;

    // Packing and frame-flush sequencing; produces at most one push per cycle
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        part_d      = part_q;
        hold_d      = hold_q;
        hold_v_d    = hold_v_q;
        len_d       = len_q;
        frame_len_d = frame_len_q;
        flv_d       = 1'b0;
        perr_d      = perr_q;
        new_word    = part_q;
        push        = 1'b0;
        push_word   = '0;
        push_keep   = '0;
        push_last   = 1'b0;
        unique case (state_q)
            ACC: begin
                if (data_valid_i) begin
                    if (byte_cnt_q == 2'd0 && hold_v_q) begin
                        push      = 1'b1;
                        push_word = hold_q;
                        push_keep = 4'hF;
                        hold_v_d  = 1'b0;
                    end
                    unique case (byte_cnt_q)
                        2'd0: new_word[31:24] = data_i;
                        2'd1: new_word[23:16] = data_i;
                        2'd2: new_word[15:8]  = data_i;
                        2'd3: new_word[7:0]   = data_i;
                    endcase
                    if (byte_cnt_q == 2'd3) begin
                        hold_d   = new_word;
                        hold_v_d = 1'b1;
                        part_d   = '0;
                    end else begin
                        part_d = new_word;
                    end
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (len_q != {W_LEN{1'b1}}) begin
                        len_d = len_q + W_LEN'(1);
                    end
                end
                if (pic_ready_i) begin
                    state_d = FLUSH_H;
                end
            end
            FLUSH_H: begin
                if (data_valid_i) begin
                    perr_d = 1'b1;
                end
                if (hold_v_q) begin
                    push      = 1'b1;
                    push_word = hold_q;
                    push_keep = 4'hF;
                    push_last = (byte_cnt_q == 2'd0);
                end
                hold_v_d = 1'b0;
                state_d  = FLUSH_P;
            end
            FLUSH_P: begin
                if (data_valid_i) begin
                    perr_d = 1'b1;
                end
                if (byte_cnt_q != 2'd0) begin
                    push      = 1'b1;
                    push_word = part_q;
                    push_last = 1'b1;
                    unique case (byte_cnt_q)
                        2'd1:    push_keep = 4'b1000;
                        2'd2:    push_keep = 4'b1100;
                        default: push_keep = 4'b1110;
                    endcase
                end
                byte_cnt_d  = 2'd0;
                part_d      = '0;
                frame_len_d = len_q;
                flv_d       = 1'b1;
                len_d       = '0;
                state_d     = ACC;
            end
            default: state_d = ACC;
        endcase
    end

    // FIFO bookkeeping: a full FIFO still accepts a push when a pop frees a slot
    always_comb begin
        head     = mem_q[rd_ptr_q];
        pop      = (level_q != '0) && m_ready;
        full     = level_q[DEPTH_LOG2];
        push_ok  = push && (!full || pop);
        ovf_d    = ovf_q | (push && !push_ok);
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(push_ok);
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(pop);
        level_d  = level_q;
        if (push_ok && !pop) begin
            level_d = level_q + (DEPTH_LOG2 + 1)'(1);
        end else if (pop && !push_ok) begin
            level_d = level_q - (DEPTH_LOG2 + 1)'(1);
        end
        shown_d = pop ? head : shown_q;
    end

    // State, counters and sticky flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACC;
            byte_cnt_q  <= '0;
            part_q      <= '0;
            hold_q      <= '0;
            hold_v_q    <= 1'b0;
            len_q       <= '0;
            frame_len_q <= '0;
            flv_q       <= 1'b0;
            ovf_q       <= 1'b0;
            perr_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            shown_q     <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            part_q      <= part_d;
            hold_q      <= hold_d;
            hold_v_q    <= hold_v_d;
            len_q       <= len_d;
            frame_len_q <= frame_len_d;
            flv_q       <= flv_d;
            ovf_q       <= ovf_d;
            perr_q      <= perr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            shown_q     <= shown_d;
        end
    end

    // FIFO storage; contents are only meaningful below level_q
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {push_last, push_keep, push_word};
        end
    end

    assign m_valid         = (level_q != '0);
    assign {m_last, m_keep, m_data} = m_valid ? head : shown_q;
    assign fifo_level      = level_q;
    assign frame_len       = frame_len_q;
    assign frame_len_valid = flv_q;
    assign overflow        = ovf_q;
    assign err_protocol    = perr_q;

endmodule

// File: tb/tb_jpeg_byte_packer.sv
// Directed bench for jpeg_byte_packer with a 4-word FIFO.
// Inputs change 2ns after posedge; outputs sampled on negedge.
module tb_jpeg_byte_packer;

    localparam int DL = 2;
    localparam int WL = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          data_valid_i = 1'b0;
    logic [7:0]    data_i = '0;
    logic          pic_ready_i = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [31:0]   m_data;
    logic [3:0]    m_keep;
    logic          m_last;
    logic [DL:0]   fifo_level;
    logic [WL-1:0] frame_len;
    logic          frame_len_valid;
    logic          overflow;
    logic          err_protocol;

    int checks = 0;
    int errors = 0;

    logic [36:0]   words [$];
    int            flv_cnt = 0;
    logic [WL-1:0] flen_seen = '0;

    jpeg_byte_packer #(.DEPTH_LOG2(DL), .W_LEN(WL)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_valid_i    (data_valid_i),
        .data_i          (data_i),
        .pic_ready_i     (pic_ready_i),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_data          (m_data),
        .m_keep          (m_keep),
        .m_last          (m_last),
        .fifo_level      (fifo_level),
        .frame_len       (frame_len),
        .frame_len_valid (frame_len_valid),
        .overflow        (overflow),
        .err_protocol    (err_protocol)
    );

    always #5 clk = ~clk;

    // Record every word the sink accepts and every frame_len pulse
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            words.push_back({m_last, m_keep, m_data});
        end
        if (!rst && frame_len_valid) begin
            flv_cnt++;
            flen_seen = frame_len;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic dv, input logic [7:0] d,
                        input logic pr);
        @(posedge clk);
        #2;
        data_valid_i = dv;
        data_i       = d;
        pic_ready_i  = pr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
    endtask

    task automatic clear_log();
        words.delete();
        flv_cnt   = 0;
        flen_seen = '1;
    endtask

    task automatic check_word(input string tag, input int idx,
                              input logic [36:0] exp);
        logic [36:0] w;
        w = (idx < words.size()) ? words[idx] : 37'h1f_ffff_ffff;
        check(tag, 64'(w), 64'(exp));
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_m_keep", 64'(m_keep), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_flags", 64'({overflow, err_protocol, frame_len_valid}), 64'd0);
        check("rst_frame_len", 64'(frame_len), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        m_ready = 1'b1;

        // Frame of 8 bytes, pic_ready one cycle after the last byte
        clear_log();
        for (int i = 1; i <= 8; i++) tick(1'b1, 8'(i), 1'b0);
        tick(1'b0, 8'h00, 1'b1);
        idle(8);
        @(negedge clk);
        check("f8_count", 64'(words.size()), 64'd2);
        check_word("f8_w0", 0, {1'b0, 4'hF, 32'h01020304});
        check_word("f8_w1", 1, {1'b1, 4'hF, 32'h05060708});
        check("f8_flv_pulses", 64'(flv_cnt), 64'd1);
        check("f8_len", 64'(flen_seen), 64'd8);

        // Five bytes, pic_ready on the same cycle as the last byte
        clear_log();
        tick(1'b1, 8'hAA, 1'b0);
        tick(1'b1, 8'hBB, 1'b0);
        tick(1'b1, 8'hCC, 1'b0);
        tick(1'b1, 8'hDD, 1'b0);
        tick(1'b1, 8'hEE, 1'b1);
        idle(8);
        @(negedge clk);
        check("f5_count", 64'(words.size()), 64'd2);
        check_word("f5_w0", 0, {1'b0, 4'hF, 32'hAABBCCDD});
        check_word("f5_w1", 1, {1'b1, 4'b1000, 32'hEE000000});
        check("f5_flv_pulses", 64'(flv_cnt), 64'd1);
        check("f5_len", 64'(flen_seen), 64'd5);

        // Empty frame
        clear_log();
        tick(1'b0, 8'h00, 1'b1);
        idle(6);
        @(negedge clk);
        check("empty_count", 64'(words.size()), 64'd0);
        check("empty_flv_pulses", 64'(flv_cnt), 64'd1);
        check("empty_len", 64'(flen_seen), 64'd0);
        check("empty_m_valid", 64'(m_valid), 64'd0);

        // Byte during FLUSH_H is dropped and flagged
        clear_log();
        check("perr_before", 64'(err_protocol), 64'd0);
        tick(1'b1, 8'h11, 1'b0);
        tick(1'b1, 8'h22, 1'b0);
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b1, 8'h55, 1'b0);
        idle(6);
        @(negedge clk);
        check("perr_flag", 64'(err_protocol), 64'd1);
        check("perr_count", 64'(words.size()), 64'd1);
        check_word("perr_w0", 0, {1'b1, 4'b1100, 32'h11220000});
        check("perr_len", 64'(flen_seen), 64'd2);

        // Overflow with sink stalled: 21 bytes 00..14 into a 4-word FIFO
        clear_log();
        @(posedge clk);
        #2;
        m_ready = 1'b0;
        for (int i = 0; i < 21; i++) begin
            tick(1'b1, 8'(i), 1'b0);
            @(negedge clk);
            if (i == 16) check("ovf_level_16", 64'(fifo_level), 64'd3);
            if (i == 17) check("ovf_level_17", 64'(fifo_level), 64'd4);
            if (i == 20) check("ovf_not_yet", 64'(overflow), 64'd0);
        end
        tick(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_level_full", 64'(fifo_level), 64'd4);
        check("ovf_m_valid", 64'(m_valid), 64'd1);
        @(posedge clk);
        #2;
        m_ready = 1'b1;
        idle(8);
        @(negedge clk);
        check("ovf_drain_count", 64'(words.size()), 64'd4);
        check_word("ovf_w0", 0, {1'b0, 4'hF, 32'h00010203});
        check_word("ovf_w1", 1, {1'b0, 4'hF, 32'h04050607});
        check_word("ovf_w2", 2, {1'b0, 4'hF, 32'h08090A0B});
        check_word("ovf_w3", 3, {1'b0, 4'hF, 32'h0C0D0E0F});
        check("ovf_level_empty", 64'(fifo_level), 64'd0);
        clear_log();
        tick(1'b0, 8'h00, 1'b1);
        idle(6);
        @(negedge clk);
        check("ovf_tail_count", 64'(words.size()), 64'd1);
        check_word("ovf_tail", 0, {1'b1, 4'b1000, 32'h14000000});
        check("ovf_len", 64'(flen_seen), 64'd21);
        check("ovf_sticky", 64'(overflow), 64'd1);

        // Reset mid-frame discards everything
        clear_log();
        @(posedge clk);
        #2;
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick(1'b1, 8'h61 + 8'(i), 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check("mid_level", 64'(fifo_level), 64'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_m_valid", 64'(m_valid), 64'd0);
        check("mid_rst_level", 64'(fifo_level), 64'd0);
        check("mid_rst_flags", 64'({overflow, err_protocol, frame_len_valid}), 64'd0);
        check("mid_rst_frame_len", 64'(frame_len), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        m_ready = 1'b1;
        clear_log();
        for (int i = 0; i < 4; i++) tick(1'b1, 8'h71 + 8'(i), 1'b0);
        tick(1'b0, 8'h00, 1'b1);
        idle(8);
        @(negedge clk);
        check("post_rst_count", 64'(words.size()), 64'd1);
        check_word("post_rst_w0", 0, {1'b1, 4'hF, 32'h71727374});
        check("post_rst_len", 64'(flen_seen), 64'd4);
        check("post_rst_flv_pulses", 64'(flv_cnt), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
